// File: rtl/hdscaler.sv
// Horizontal RGB downscaler: bypass, 2:1 and 4:3 ratios.
// Two-stage pipeline: stage 1 registers the pixel and phase, stage 2 does the arithmetic.
module hdscaler (
    input  logic       clk_scl,
    input  logic       rst_n_scl,
    input  logic       scl_i_de,
    input  logic [7:0] scl_i_data_r,
    input  logic [7:0] scl_i_data_g,
    input  logic [7:0] scl_i_data_b,
    input  logic [1:0] scl_cfg_mode,
    output logic       scl_o_de,
    output logic [7:0] scl_o_data_r,
    output logic [7:0] scl_o_data_g,
    output logic [7:0] scl_o_data_b
);

    typedef enum logic {IDLE, ACTIVE} state_t;
    typedef enum logic [1:0] {
        MODE_BYP  = 2'd0,
        MODE_2TO1 = 2'd1,
        MODE_4TO3 = 2'd2,
        MODE_BYP3 = 2'd3
    } mode_t;

    state_t      state;
    mode_t       mode_q;
    logic [1:0]  phase_q;
    logic [23:0] prev_q;

    logic        s1_de;
    mode_t       s1_mode;
    logic [1:0]  s1_phase;
    logic [23:0] s1_cur;
    logic [23:0] s1_prev;

    logic        line_start;
    mode_t       cur_mode;
    logic [1:0]  cur_phase;
    logic [1:0]  next_phase;
    logic        emit;

    // The first de-high cycle of a line uses the live mode and phase 0,
    // without waiting for the registered copies to update.
    always_comb begin
        line_start = scl_i_de && (state == IDLE);
        cur_mode   = line_start ? mode_t'(scl_cfg_mode) : mode_q;
        cur_phase  = line_start ? 2'd0 : phase_q;
        next_phase = 2'd0;
        case (cur_mode)
            MODE_2TO1: next_phase = (cur_phase == 2'd1) ? 2'd0 : 2'd1;
            MODE_4TO3: next_phase = cur_phase + 2'd1;
            default:   next_phase = 2'd0;
        endcase
    end

    always_comb begin
        emit = 1'b0;
        if (s1_de) begin
            case (s1_mode)
                MODE_2TO1: emit = (s1_phase == 2'd1);
                MODE_4TO3: emit = (s1_phase != 2'd0);
                default:   emit = 1'b1;
            endcase
        end
    end

    function automatic logic [7:0] calc(input mode_t mode, input logic [1:0] ph,
                                        input logic [7:0] p, input logic [7:0] c);
        logic [9:0] a10;
        logic [9:0] b10;
        logic [9:0] sum;
        logic [7:0] res;
        a10 = {2'b00, p};
        b10 = {2'b00, c};
        sum = '0;
        res = c;
        if (mode == MODE_2TO1 || (mode == MODE_4TO3 && ph == 2'd2)) begin
            sum = a10 + b10 + 10'd1;
            res = sum[8:1];
        end else if (mode == MODE_4TO3 && ph == 2'd1) begin
            sum = a10 + a10 + a10 + b10 + 10'd2;
            res = sum[9:2];
        end else if (mode == MODE_4TO3 && ph == 2'd3) begin
            sum = a10 + b10 + b10 + b10 + 10'd2;
            res = sum[9:2];
        end
        return res;
    endfunction

    always_ff @(posedge clk_scl or negedge rst_n_scl) begin
        if (!rst_n_scl) begin
            state    <= IDLE;
            mode_q   <= MODE_BYP;
            phase_q  <= '0;
            prev_q   <= '0;
            s1_de    <= 1'b0;
            s1_mode  <= MODE_BYP;
            s1_phase <= '0;
            s1_cur   <= '0;
            s1_prev  <= '0;
        end else begin
            state <= scl_i_de ? ACTIVE : IDLE;
            if (scl_i_de) begin
                mode_q  <= cur_mode;
                phase_q <= next_phase;
                prev_q  <= {scl_i_data_r, scl_i_data_g, scl_i_data_b};
            end
            s1_de    <= scl_i_de;
            s1_mode  <= cur_mode;
            s1_phase <= cur_phase;
            s1_cur   <= {scl_i_data_r, scl_i_data_g, scl_i_data_b};
            s1_prev  <= prev_q;
        end
    end

    always_ff @(posedge clk_scl or negedge rst_n_scl) begin
        if (!rst_n_scl) begin
            scl_o_de     <= 1'b0;
            scl_o_data_r <= '0;
            scl_o_data_g <= '0;
            scl_o_data_b <= '0;
        end else begin
            scl_o_de <= emit;
            if (emit) begin
                scl_o_data_r <= calc(s1_mode, s1_phase, s1_prev[23:16], s1_cur[23:16]);
                scl_o_data_g <= calc(s1_mode, s1_phase, s1_prev[15:8],  s1_cur[15:8]);
                scl_o_data_b <= calc(s1_mode, s1_phase, s1_prev[7:0],   s1_cur[7:0]);
            end
        end
    end

endmodule

// File: tb/tb_hdscaler.sv
// Directed bench for hdscaler: each task drives one scenario and checks the
// recorded output strobes against hand-computed values and cycle offsets.
module tb_hdscaler;

    logic       clk_scl = 1'b0;
    logic       rst_n_scl = 1'b0;
    logic       scl_i_de = 1'b0;
    logic [7:0] scl_i_data_r = '0;
    logic [7:0] scl_i_data_g = '0;
    logic [7:0] scl_i_data_b = '0;
    logic [1:0] scl_cfg_mode = '0;
    logic       scl_o_de;
    logic [7:0] scl_o_data_r;
    logic [7:0] scl_o_data_g;
    logic [7:0] scl_o_data_b;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef logic [7:0] pix8_t [8];
    typedef struct {
        int         cyc;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } obs_t;
    obs_t mon_q[$];

    hdscaler dut (
        .clk_scl      (clk_scl),
        .rst_n_scl    (rst_n_scl),
        .scl_i_de     (scl_i_de),
        .scl_i_data_r (scl_i_data_r),
        .scl_i_data_g (scl_i_data_g),
        .scl_i_data_b (scl_i_data_b),
        .scl_cfg_mode (scl_cfg_mode),
        .scl_o_de     (scl_o_de),
        .scl_o_data_r (scl_o_data_r),
        .scl_o_data_g (scl_o_data_g),
        .scl_o_data_b (scl_o_data_b)
    );

    always #5 clk_scl = ~clk_scl;
    always @(posedge clk_scl) cyc <= cyc + 1;

    // An input driven when cyc == k shows up on the outputs when cyc == k + 2.
    always @(negedge clk_scl) begin
        if (scl_o_de === 1'b1)
            mon_q.push_back('{cyc, scl_o_data_r, scl_o_data_g, scl_o_data_b});
    end

    task automatic drive_px(input logic de, input logic [7:0] r, input logic [7:0] g,
                            input logic [7:0] b, input logic [1:0] mode, output int c);
        @(negedge clk_scl);
        scl_i_de     = de;
        scl_i_data_r = r;
        scl_i_data_g = g;
        scl_i_data_b = b;
        scl_cfg_mode = mode;
        c = cyc;
    endtask

    task automatic idle(input int n);
        int c;
        for (int i = 0; i < n; i++) drive_px(1'b0, 8'd0, 8'd0, 8'd0, 2'd0, c);
    endtask

    task automatic drive_line(input pix8_t px, input int n, input logic [1:0] mode, output int start);
        int c;
        start = 0;
        for (int i = 0; i < n; i++) begin
            drive_px(1'b1, px[i], px[i], px[i], mode, c);
            if (i == 0) start = c;
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk_scl);
        #1;
        checks++;
        if (scl_o_de !== 1'b0 || scl_o_data_r !== 8'd0 || scl_o_data_g !== 8'd0 || scl_o_data_b !== 8'd0) begin
            failures++;
            $display("FAIL reset_outputs: de=%b r=%0d g=%0d b=%0d expected all 0",
                     scl_o_de, scl_o_data_r, scl_o_data_g, scl_o_data_b);
        end
        @(negedge clk_scl);
        rst_n_scl = 1'b1;
        idle(2);
    endtask

    task automatic test_bypass;
        pix8_t px;
        int s;
        px = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd0, 8'd0, 8'd0};
        mon_q.delete();
        drive_line(px, 5, 2'd0, s);
        idle(4);
        checks++;
        if (mon_q.size() != 5) begin
            failures++;
            $display("FAIL bypass_count: got %0d expected 5", mon_q.size());
        end
        for (int i = 0; i < 5 && i < mon_q.size(); i++) begin
            checks++;
            if (mon_q[i].r !== px[i] || mon_q[i].g !== px[i] || mon_q[i].b !== px[i] || mon_q[i].cyc != s + i + 2) begin
                failures++;
                $display("FAIL bypass_px%0d: r=%0d g=%0d b=%0d at +%0d expected %0d at +%0d",
                         i, mon_q[i].r, mon_q[i].g, mon_q[i].b, mon_q[i].cyc - s, px[i], i + 2);
            end
        end
        // mode 3 behaves as bypass
        px = '{8'd77, 8'd3, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        mon_q.delete();
        drive_line(px, 2, 2'd3, s);
        idle(4);
        checks++;
        if (mon_q.size() != 2 || mon_q[0].r !== 8'd77 || mon_q[1].r !== 8'd3 || mon_q[0].cyc != s + 2) begin
            failures++;
            $display("FAIL mode3_bypass: count=%0d expected 2 with r=77,3 at +2", mon_q.size());
        end
    endtask

    task automatic test_2to1;
        pix8_t px;
        int s;
        int ev[2];
        int eo[2];
        px = '{8'd0, 8'd255, 8'd100, 8'd101, 8'd7, 8'd0, 8'd0, 8'd0};
        ev = '{128, 101};
        eo = '{3, 5};
        mon_q.delete();
        drive_line(px, 5, 2'd1, s);
        idle(4);
        checks++;
        if (mon_q.size() != 2) begin
            failures++;
            $display("FAIL 2to1_count: got %0d expected 2", mon_q.size());
        end
        for (int i = 0; i < 2 && i < mon_q.size(); i++) begin
            checks++;
            if (mon_q[i].r !== 8'(ev[i]) || mon_q[i].cyc != s + eo[i]) begin
                failures++;
                $display("FAIL 2to1_out%0d: r=%0d at +%0d expected %0d at +%0d",
                         i, mon_q[i].r, mon_q[i].cyc - s, ev[i], eo[i]);
            end
        end
        #1;
        checks++;
        if (scl_o_de !== 1'b0 || scl_o_data_r !== 8'd101) begin
            failures++;
            $display("FAIL 2to1_hold: de=%b r=%0d expected de=0 r=101", scl_o_de, scl_o_data_r);
        end
    endtask

    task automatic test_channels;
        int s;
        int c;
        mon_q.delete();
        drive_px(1'b1, 8'd0, 8'd10, 8'd1, 2'd1, s);
        drive_px(1'b1, 8'd255, 8'd20, 8'd2, 2'd1, c);
        idle(4);
        checks++;
        if (mon_q.size() != 1 || mon_q[0].r !== 8'd128 || mon_q[0].g !== 8'd15 || mon_q[0].b !== 8'd2) begin
            failures++;
            $display("FAIL channels: count=%0d expected 1 output r=128 g=15 b=2", mon_q.size());
        end
    endtask

    task automatic test_4to3;
        pix8_t px;
        int s;
        int ev[5];
        px = '{8'd0, 8'd4, 8'd8, 8'd12, 8'd20, 8'd40, 8'd60, 8'd0};
        ev = '{1, 6, 11, 25, 50};
        mon_q.delete();
        drive_line(px, 4, 2'd2, s);
        idle(4);
        checks++;
        if (mon_q.size() != 3) begin
            failures++;
            $display("FAIL 4to3_count: got %0d expected 3", mon_q.size());
        end
        for (int i = 0; i < 3 && i < mon_q.size(); i++) begin
            checks++;
            if (mon_q[i].r !== 8'(ev[i]) || mon_q[i].cyc != s + i + 3) begin
                failures++;
                $display("FAIL 4to3_out%0d: r=%0d at +%0d expected %0d at +%0d",
                         i, mon_q[i].r, mon_q[i].cyc - s, ev[i], i + 3);
            end
        end
        // 7-pixel line: trailing 3 pixels yield 2 outputs
        mon_q.delete();
        drive_line(px, 7, 2'd2, s);
        idle(4);
        checks++;
        if (mon_q.size() != 5) begin
            failures++;
            $display("FAIL 4to3_partial_count: got %0d expected 5", mon_q.size());
        end
        for (int i = 0; i < 5 && i < mon_q.size(); i++) begin
            checks++;
            if (mon_q[i].r !== 8'(ev[i])) begin
                failures++;
                $display("FAIL 4to3_partial_out%0d: r=%0d expected %0d", i, mon_q[i].r, ev[i]);
            end
        end
    endtask

    task automatic test_4to3_full_scale;
        pix8_t px;
        int s;
        int bad;
        px = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255};
        mon_q.delete();
        drive_line(px, 8, 2'd2, s);
        idle(4);
        bad = 0;
        foreach (mon_q[i])
            if (mon_q[i].r !== 8'd255 || mon_q[i].g !== 8'd255 || mon_q[i].b !== 8'd255) bad++;
        checks++;
        if (mon_q.size() != 6 || bad != 0) begin
            failures++;
            $display("FAIL 4to3_full_scale: count=%0d bad=%0d expected 6 outputs all 255", mon_q.size(), bad);
        end
    endtask

    task automatic test_mode_switch;
        int s;
        int c;
        int ev[3];
        pix8_t px;
        ev = '{15, 35, 55};
        mon_q.delete();
        drive_px(1'b1, 8'd10, 8'd10, 8'd10, 2'd1, s);
        drive_px(1'b1, 8'd20, 8'd20, 8'd20, 2'd1, c);
        for (int i = 3; i <= 6; i++)
            drive_px(1'b1, 8'(i * 10), 8'(i * 10), 8'(i * 10), 2'd2, c);
        idle(4);
        checks++;
        if (mon_q.size() != 3) begin
            failures++;
            $display("FAIL switch_count: got %0d expected 3", mon_q.size());
        end
        for (int i = 0; i < 3 && i < mon_q.size(); i++) begin
            checks++;
            if (mon_q[i].r !== 8'(ev[i]) || mon_q[i].cyc != s + 2 * i + 3) begin
                failures++;
                $display("FAIL switch_out%0d: r=%0d at +%0d expected %0d at +%0d",
                         i, mon_q[i].r, mon_q[i].cyc - s, ev[i], 2 * i + 3);
            end
        end
        px = '{8'd0, 8'd4, 8'd8, 8'd12, 8'd0, 8'd0, 8'd0, 8'd0};
        mon_q.delete();
        drive_line(px, 4, 2'd2, s);
        idle(4);
        checks++;
        if (mon_q.size() != 3 || mon_q[0].r !== 8'd1 || mon_q[2].r !== 8'd11) begin
            failures++;
            $display("FAIL switch_next_line: count=%0d expected 3 outputs 1,6,11", mon_q.size());
        end
    endtask

    task automatic test_back_to_back;
        int s;
        int c;
        pix8_t px;
        px = '{8'd0, 8'd4, 8'd8, 8'd12, 8'd0, 8'd0, 8'd0, 8'd0};
        mon_q.delete();
        drive_px(1'b1, 8'd2, 8'd2, 8'd2, 2'd1, c);
        drive_px(1'b1, 8'd4, 8'd4, 8'd4, 2'd1, c);
        drive_px(1'b1, 8'd6, 8'd6, 8'd6, 2'd1, c);
        drive_px(1'b0, 8'd0, 8'd0, 8'd0, 2'd2, c);
        drive_line(px, 4, 2'd2, s);
        idle(4);
        checks++;
        if (mon_q.size() != 4) begin
            failures++;
            $display("FAIL b2b_count: got %0d expected 4", mon_q.size());
        end else begin
            checks++;
            if (mon_q[0].r !== 8'd3 || mon_q[1].r !== 8'd1 || mon_q[1].cyc != s + 3 ||
                mon_q[2].r !== 8'd6 || mon_q[3].r !== 8'd11) begin
                failures++;
                $display("FAIL b2b_values: r=%0d,%0d,%0d,%0d expected 3,1,6,11",
                         mon_q[0].r, mon_q[1].r, mon_q[2].r, mon_q[3].r);
            end
        end
    endtask

    task automatic test_reset_midline;
        int s;
        int c;
        mon_q.delete();
        drive_px(1'b1, 8'd0, 8'd0, 8'd0, 2'd2, c);
        drive_px(1'b1, 8'd4, 8'd4, 8'd4, 2'd2, c);
        drive_px(1'b1, 8'd8, 8'd8, 8'd8, 2'd2, c);
        rst_n_scl = 1'b0;
        #1;
        checks++;
        if (scl_o_de !== 1'b0 || scl_o_data_r !== 8'd0) begin
            failures++;
            $display("FAIL midreset_outputs: de=%b r=%0d expected 0,0", scl_o_de, scl_o_data_r);
        end
        drive_px(1'b1, 8'd12, 8'd12, 8'd12, 2'd1, c);
        #1;
        checks++;
        if (scl_o_de !== 1'b0 || scl_o_data_r !== 8'd0 || scl_o_data_b !== 8'd0) begin
            failures++;
            $display("FAIL midreset_hold: de=%b r=%0d b=%0d expected 0,0,0", scl_o_de, scl_o_data_r, scl_o_data_b);
        end
        @(negedge clk_scl);
        rst_n_scl = 1'b1;
        scl_i_data_r = 8'd100;
        scl_i_data_g = 8'd100;
        scl_i_data_b = 8'd100;
        s = cyc;
        drive_px(1'b1, 8'd110, 8'd110, 8'd110, 2'd1, c);
        drive_px(1'b1, 8'd120, 8'd120, 8'd120, 2'd2, c);
        drive_px(1'b1, 8'd130, 8'd130, 8'd130, 2'd2, c);
        idle(4);
        checks++;
        if (mon_q.size() != 2) begin
            failures++;
            $display("FAIL midreset_count: got %0d expected 2", mon_q.size());
        end else begin
            checks++;
            if (mon_q[0].r !== 8'd105 || mon_q[0].cyc != s + 3 || mon_q[1].r !== 8'd125) begin
                failures++;
                $display("FAIL midreset_values: r=%0d at +%0d, r=%0d expected 105 at +3, 125",
                         mon_q[0].r, mon_q[0].cyc - s, mon_q[1].r);
            end
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_2to1();
        test_channels();
        test_4to3();
        test_4to3_full_scale();
        test_mode_switch();
        test_back_to_back();
        test_reset_midline();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
